// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port Avalon-MM arbiter onto one SDRAM master with in-order read return routing
// Optional feature macro: SDRAM_ARB_ROUND_ROBIN_EN (round-robin on contention; default is fixed priority, port 0 first)
module sdram_arbiter #(
  parameter int ADDR_W          = 24,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [ADDR_W-1:0]     p0_address,
  input  logic                  p0_read,
  input  logic                  p0_write,
  input  logic [DATA_W-1:0]     p0_writedata,
  input  logic [DATA_W/8-1:0]   p0_byteenable,
  output logic                  p0_waitrequest,
  output logic [DATA_W-1:0]     p0_readdata,
  output logic                  p0_readdatavalid,
  input  logic [ADDR_W-1:0]     p1_address,
  input  logic                  p1_read,
  input  logic                  p1_write,
  input  logic [DATA_W-1:0]     p1_writedata,
  input  logic [DATA_W/8-1:0]   p1_byteenable,
  output logic                  p1_waitrequest,
  output logic [DATA_W-1:0]     p1_readdata,
  output logic                  p1_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  output logic                  arb_error
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   m_address_q;
  logic                m_read_q;
  logic                m_write_q;
  logic [DATA_W-1:0]   m_writedata_q;
  logic [BE_W-1:0]     m_byteenable_q;

  // Read-owner tag FIFO: one entry per read accepted by the controller
  logic                tag_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                arb_error_q;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic                last_q;
`endif

  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic grant_d;
  logic accept;
  logic push;
  logic pop;
  logic head;

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  // Writes never need a tag slot, so only reads are throttled by a full FIFO
  assign elig0 = p0_write | (p0_read & ~fifo_full);
  assign elig1 = p1_write | (p1_read & ~fifo_full);

  // Acceptance is suppressed during reset so an aborted command is never acknowledged
  assign accept = reset_reset_n & (state_q == ISSUE) & ~m_waitrequest;
  assign push   = accept & m_read_q;
  assign pop    = m_readdatavalid & ~fifo_empty;
  assign head   = tag_q[rd_ptr_q];

  // Winner selection among eligible requesters
  always_comb begin
    grant_d = 1'b0;
    if (elig0 && elig1) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      grant_d = ~last_q;
`else
      grant_d = 1'b0;
`endif
    end else if (elig1) begin
      grant_d = 1'b1;
    end
  end

  // Tag count next state: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Command FSM: capture the winner in IDLE, hold it on m_* until the controller accepts
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      m_address_q    <= '0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= '0;
      m_byteenable_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (elig0 || elig1) begin
            owner_q        <= grant_d;
            m_address_q    <= grant_d ? p1_address    : p0_address;
            m_read_q       <= grant_d ? p1_read       : p0_read;
            m_write_q      <= grant_d ? p1_write      : p0_write;
            m_writedata_q  <= grant_d ? p1_writedata  : p0_writedata;
            m_byteenable_q <= grant_d ? p1_byteenable : p0_byteenable;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!m_waitrequest) begin
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag FIFO pointers and storage; reset discards all outstanding tags
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= owner_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Sticky error: a read return arrived with no read outstanding
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      arb_error_q <= 1'b0;
    end else if (m_readdatavalid && fifo_empty) begin
      arb_error_q <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Last-grant pointer, starts at port 1 so port 0 wins the first contention
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= owner_q;
    end
  end
`endif

  assign m_address    = m_address_q;
  assign m_read       = m_read_q;
  assign m_write      = m_write_q;
  assign m_writedata  = m_writedata_q;
  assign m_byteenable = m_byteenable_q;

  assign p0_waitrequest = ~(accept & ~owner_q);
  assign p1_waitrequest = ~(accept &  owner_q);

  assign p0_readdata      = m_readdata;
  assign p1_readdata      = m_readdata;
  assign p0_readdatavalid = reset_reset_n & pop & ~head;
  assign p1_readdatavalid = reset_reset_n & pop &  head;

  assign arb_error = arb_error_q;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24: word address width of all Avalon-MM ports.
REQ-002 Parameter DATA_W, default 32: data width; byteenable width is DATA_W/8.
REQ-003 Parameter MAX_OUTSTANDING, default 8, power of 2: depth of the read-owner tag FIFO.
REQ-004 clk_clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset_reset_n  in  1  synchronous, active-low reset.
REQ-006 pN_address  in  ADDR_W  requester N (N=0,1) word address.
REQ-007 pN_read / pN_write  in  1 each  requester N command strobes; never both high.
REQ-008 pN_writedata  in  DATA_W; pN_byteenable  in  DATA_W/8.
REQ-009 pN_waitrequest  out  1  low only in the cycle that requester N's command is accepted.
REQ-010 pN_readdata  out  DATA_W; pN_readdatavalid  out  1  routed read return.
REQ-011 m_address, m_read, m_write, m_writedata, m_byteenable  out  as above  single master port to the SDRAM controller.
REQ-012 m_waitrequest, m_readdata, m_readdatavalid  in  SDRAM controller responses.
REQ-013 arb_error  out  1  sticky protocol-error flag.

Function
REQ-014 FSM states IDLE and ISSUE; IDLE selects a winner among eligible requesters, registers its command onto m_* and moves to ISSUE on the next edge.
REQ-015 A requester is eligible when pN_read or pN_write is high; a read is ineligible while the tag FIFO is full, and writes remain eligible.
REQ-016 ISSUE holds m_* stable until m_waitrequest is low; in that cycle the owner's pN_waitrequest is low (combinational), a read pushes the owner ID into the tag FIFO, and the next state is IDLE with m_read/m_write cleared.
REQ-017 The minimum command latency is 2 cycles from request to acceptance when m_waitrequest is low; the non-owner port always sees pN_waitrequest high.
REQ-018 pN_readdata equals m_readdata for both ports; pN_readdatavalid = m_readdatavalid AND (FIFO head == N); each m_readdatavalid pops one entry.
REQ-019 A push and a pop in the same cycle are both performed and leave the count unchanged; the pointers wrap modulo MAX_OUTSTANDING.
REQ-020 m_readdatavalid while the FIFO is empty is dropped (no pN_readdatavalid) and sets arb_error until reset.
REQ-021 Read returns are delivered in issue order across both ports; no reordering is permitted.

Reset
REQ-022 While reset_reset_n is low at the clock edge: state is IDLE, m_read=m_write=0, m_address/m_writedata=0, m_byteenable=0, FIFO empty, arb_error=0, last-grant pointer=1.
REQ-023 pN_waitrequest is high and pN_readdatavalid is low during reset.
REQ-024 A reset applied mid-ISSUE aborts the command without acceptance; outstanding read tags are discarded.

Configuration
REQ-025 With macro SDRAM_ARB_ROUND_ROBIN_EN defined, on contention the port not granted last wins, and the last-grant pointer updates on each acceptance.
REQ-026 Without SDRAM_ARB_ROUND_ROBIN_EN, port 0 always wins on contention (fixed priority), and the pointer is unused.

Verification
REQ-027 Port-0 write to addr 0x000010, data 0xDEADBEEF, m_waitrequest low -> m_write high one cycle after the request, and p0_waitrequest low in the second cycle.
REQ-028 Both ports read simultaneously with RR enabled after reset -> p0 granted first, then p1; returns 0x11111111 and 0x22222222 appear on p0 and then p1 readdatavalid respectively.
REQ-029 9 reads issued with MAX_OUTSTANDING=8 and no returns -> 9th read is held off (waitrequest high) while a concurrent p1 write is still accepted.
REQ-030 m_waitrequest held high 5 cycles during ISSUE -> m_* stable for all 5 cycles, with acceptance on the 6th.
REQ-031 m_readdatavalid pulsed with an empty FIFO -> no pN_readdatavalid, and arb_error=1 until reset_reset_n=0.
